// File: rtl/uarttx_pkg.sv
// Shared definitions for the UART frame transmit path.
// Holds the frame width, the default send-strobe hold time and
// completion timeout, and the arbiter state encoding.
package uarttx_pkg;

    localparam int FRAME_W_DEFAULT   = 9;
    localparam int SEND_HOLD_DEFAULT = 25;
    localparam int TIMEOUT_DEFAULT   = 4095;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/tx_frame_arbiter_rr_select.sv
// rr_select: combinational round-robin priority picker.
// Finds the first set bit of req, searching ptr, ptr+1, ... modulo N_REQ.
// Ports:
//   req   - request vector, one bit per source
//   ptr   - index holding first priority
//   valid - at least one request is set
//   index - winning source index (0 when valid is low)
module rr_select #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // One spare bit so ptr+k can exceed N_REQ-1 before being wrapped back;
    // this keeps the wrap correct when N_REQ is not a power of two.
    logic [IDX_W:0] pos;

    // Walk the sources in priority order and keep the first requester.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N_REQ)) begin
                pos = pos - (IDX_W+1)'(N_REQ);
            end
            if (!valid && req[pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                index = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: shares one UART frame transmitter between N_REQ sources.
// Requests are granted round-robin; the winner's frame is latched, send is
// held for SEND_HOLD cycles, and the transmitter's busy flag is followed to
// completion, which yields a one-cycle ack to the winner. If completion does
// not arrive within TIMEOUT cycles of the send rise, timeout_err pulses and
// the faulty source drops to lowest priority.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req               - level request per source, held until ack
//   frame_in          - source i frame at [i*FRAME_W +: FRAME_W]
//   tx_busy           - transmitter busy flag
//   frame_to_transmit - latched frame of the current/last grant
//   send              - transmit strobe
//   ack               - one-hot, one-cycle completion pulse
//   grant_id          - index of the current/last grant
//   active            - arbiter is not idle
//   timeout_err       - one-cycle pulse on abort
module tx_frame_arbiter
    import uarttx_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FRAME_W   = FRAME_W_DEFAULT,
    parameter int SEND_HOLD = SEND_HOLD_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*FRAME_W-1:0] frame_in,
    input  logic                     tx_busy,
    output logic [FRAME_W-1:0]       frame_to_transmit,
    output logic                     send,
    output logic [N_REQ-1:0]         ack,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     active,
    output logic                     timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    arb_state_t         state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [7:0]         hold_cnt, hold_n;
    logic [TO_W-1:0]    to_cnt, to_n;
    logic               seen_busy, seen_n;

    logic [FRAME_W-1:0] frame_n;
    logic               send_n;
    logic [N_REQ-1:0]   ack_n;
    logic [IDX_W-1:0]   grant_n;
    logic               active_n;
    logic               timeout_n;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [FRAME_W-1:0] frame_sel;
    logic [IDX_W-1:0]   next_ptr;
    logic [TO_W-1:0]    to_inc;
    logic               to_hit;

    rr_select #(
        .N_REQ (N_REQ)
    ) u_rr_select (
        .req   (req),
        .ptr   (ptr),
        .valid (sel_valid),
        .index (sel_idx)
    );

    // Mux out the candidate winner's frame.
    always_comb begin
        frame_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                frame_sel = frame_in[i*FRAME_W +: FRAME_W];
            end
        end
    end

    // Priority moves to the source after the one just served, so a source
    // that keeps requesting waits behind everybody else.
    assign next_ptr = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Saturating timeout increment; to_hit flags the cycle it reaches TIMEOUT.
    assign to_inc = (to_cnt == TO_W'(TIMEOUT)) ? to_cnt : to_cnt + 1'b1;
    assign to_hit = (to_inc == TO_W'(TIMEOUT));

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so send rises in the first SEND cycle and ack is high
    // exactly while the machine sits in DONE.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        to_n      = to_cnt;
        seen_n    = seen_busy;
        frame_n   = frame_to_transmit;
        send_n    = send;
        ack_n     = '0;
        grant_n   = grant_id;
        timeout_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!tx_busy && sel_valid) begin
                    state_n = ST_SEND;
                    grant_n = sel_idx;
                    frame_n = frame_sel;
                    hold_n  = '0;
                    to_n    = '0;
                    seen_n  = 1'b0;
                    send_n  = 1'b1;
                end
            end

            ST_SEND: begin
                seen_n = seen_busy | tx_busy;
                hold_n = hold_cnt + 8'd1;
                to_n   = to_inc;
                if (to_hit) begin
                    state_n   = ST_IDLE;
                    send_n    = 1'b0;
                    timeout_n = 1'b1;
                    ptr_n     = next_ptr;
                end else if (hold_cnt == 8'(SEND_HOLD - 1)) begin
                    state_n = ST_WAIT;
                    send_n  = 1'b0;
                end
            end

            ST_WAIT: begin
                seen_n = seen_busy | tx_busy;
                to_n   = to_inc;
                // Completion wins over a timeout landing in the same cycle.
                if (seen_busy && !tx_busy) begin
                    state_n        = ST_DONE;
                    ack_n[grant_id] = 1'b1;
                end else if (to_hit) begin
                    state_n   = ST_IDLE;
                    send_n    = 1'b0;
                    timeout_n = 1'b1;
                    ptr_n     = next_ptr;
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
                ptr_n   = next_ptr;
            end

            default: begin
                state_n = ST_IDLE;
                send_n  = 1'b0;
            end
        endcase

        active_n = (state_n != ST_IDLE);
    end

    // State, counters and all outputs; reset clears everything at once,
    // so an in-flight send is dropped without ack or timeout_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            ptr               <= '0;
            hold_cnt          <= '0;
            to_cnt            <= '0;
            seen_busy         <= 1'b0;
            frame_to_transmit <= '0;
            send              <= 1'b0;
            ack               <= '0;
            grant_id          <= '0;
            active            <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            state             <= state_n;
            ptr               <= ptr_n;
            hold_cnt          <= hold_n;
            to_cnt            <= to_n;
            seen_busy         <= seen_n;
            frame_to_transmit <= frame_n;
            send              <= send_n;
            ack               <= ack_n;
            grant_id          <= grant_n;
            active            <= active_n;
            timeout_err       <= timeout_n;
        end
    end

endmodule
